// File: rtl/amstrad_mmu_pkg.sv
// Shared constants for the Amstrad expansion MMU: ASIC unlock sequence,
// register write codes and RAM page constants.
package amstrad_mmu_pkg;

  localparam int unsigned SEQ_LEN     = 17;
  localparam int unsigned BASE_PAGE   = 2;
  localparam int unsigned PAGE_OFFSET = 3;

  // Entry 0 is the first byte sent (FF), entry 16 the last (EE)
  localparam logic [SEQ_LEN-1:0][7:0] UNLOCK_SEQ = {
    8'hEE, 8'hCD, 8'h8A, 8'h15, 8'h2B, 8'h46, 8'h9C, 8'h39, 8'h62,
    8'hD4, 8'hA8, 8'h51, 8'hB3, 8'h77, 8'hFF, 8'h00, 8'hFF
  };

  localparam logic [2:0] RMR2_CODE = 3'b101;
  localparam logic [1:0] MMR_CODE  = 2'b11;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_SEQ      = 2'd1,
    ST_UNLOCKED = 2'd2
  } unlock_state_t;

endpackage

// File: rtl/asic_unlock_fsm.sv
// Plus ASIC unlock detector: tracks the 17-byte unlock sequence written to
// port BCxx and reports when the ASIC registers are unlocked.
module asic_unlock_fsm
  import amstrad_mmu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_event,
  input  logic [7:0] i_byte,
  input  logic       i_plus_mode,
  output logic       o_unlocked
);

  unlock_state_t r_state;
  logic [4:0]    r_idx;

  // r_idx holds the index of the next expected sequence byte
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_LOCKED;
      r_idx      <= 5'd0;
      o_unlocked <= 1'b0;
    end else if (!i_plus_mode) begin
      r_state    <= ST_LOCKED;
      r_idx      <= 5'd0;
      o_unlocked <= 1'b0;
    end else if (i_event) begin
      if (r_state != ST_UNLOCKED && i_byte == UNLOCK_SEQ[r_idx]) begin
        if (r_idx == 5'(SEQ_LEN - 1)) begin
          r_state    <= ST_UNLOCKED;
          r_idx      <= 5'd0;
          o_unlocked <= 1'b1;
        end else begin
          r_state    <= ST_SEQ;
          r_idx      <= r_idx + 5'd1;
          o_unlocked <= 1'b0;
        end
      end else if (i_byte == 8'hFF) begin
        r_state    <= ST_SEQ;
        r_idx      <= 5'd1;
        o_unlocked <= 1'b0;
      end else begin
        r_state    <= ST_LOCKED;
        r_idx      <= 5'd0;
        o_unlocked <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/amstrad_mmu_ext.sv
// Amstrad CPC expansion MMU: RAM banking, upper/lower ROM selection and
// Plus ASIC unlock / register-page decode producing a flat physical address.
module amstrad_mmu_ext
  import amstrad_mmu_pkg::*;
#(
  parameter int unsigned RAM_PAGE_BITS = 5,
  parameter int unsigned EXT_A_BITS    = 1,
  parameter int unsigned ROM_BANK_BITS = 8,
  parameter int unsigned ADDR_W        = 23
) (
  input  logic                          CLK,
  input  logic                          reset_n,
  input  logic                          ram64k,
  input  logic                          romen_n,
  input  logic [(2**ROM_BANK_BITS)-1:0] rom_map,
  input  logic                          plus_mode,
  input  logic                          io_WR,
  input  logic [7:0]                    D,
  input  logic [15:0]                   A,
  output logic [ADDR_W-1:0]             ram_A,
  output logic                          asic_unlocked,
  output logic                          asic_page
);

  localparam int unsigned SEL_W = EXT_A_BITS + 3;

  logic                     r_old_wr;
  logic [RAM_PAGE_BITS-1:0] r_page;
  logic [2:0]               r_map;
  logic [ROM_BANK_BITS-1:0] r_rom_bank;
  logic [1:0]               r_lrom_loc;
  logic [2:0]               r_lrom_bank;

  logic                     w_event;
  logic                     w_mmr_wr;
  logic                     w_rom_wr;
  logic                     w_rmr2_wr;
  logic                     w_asic_evt;
  logic                     w_unlocked;
  logic [SEL_W-1:0]         w_mmr_sel;
  logic [RAM_PAGE_BITS-1:0] w_page_next;
  logic [ROM_BANK_BITS-1:0] w_rom_idx;
  logic                     w_lrom_hit;
  logic [RAM_PAGE_BITS-1:0] w_pg;
  logic [1:0]               w_blk;

  // Inverted high port-address bits extend the page number
  generate
    if (EXT_A_BITS == 0) begin : g_no_ext
      assign w_mmr_sel = D[5:3];
    end else begin : g_ext
      assign w_mmr_sel = {~A[8 +: EXT_A_BITS], D[5:3]};
    end
  endgenerate

  assign w_event     = io_WR & ~r_old_wr;
  assign w_mmr_wr    = w_event & ~A[15] & (D[7:6] == MMR_CODE) & ~ram64k;
  assign w_rom_wr    = w_event & ~A[13];
  assign w_rmr2_wr   = w_event & w_unlocked & ~A[15] & (D[7:5] == RMR2_CODE);
  assign w_asic_evt  = w_event & (A[15:8] == 8'hBC);
  assign w_page_next = RAM_PAGE_BITS'(w_mmr_sel) + RAM_PAGE_BITS'(PAGE_OFFSET);
  assign w_rom_idx   = ROM_BANK_BITS'(D);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_old_wr    <= 1'b0;
      r_page      <= RAM_PAGE_BITS'(PAGE_OFFSET);
      r_map       <= 3'd0;
      r_rom_bank  <= '0;
      r_lrom_loc  <= 2'b00;
      r_lrom_bank <= 3'd0;
    end else begin
      r_old_wr <= io_WR;
      if (w_mmr_wr) begin
        r_page <= w_page_next;
        r_map  <= D[2:0];
      end
      if (w_rom_wr) begin
        r_rom_bank <= rom_map[w_rom_idx] ? w_rom_idx : '0;
      end
      if (w_rmr2_wr) begin
        r_lrom_loc  <= D[4:3];
        r_lrom_bank <= D[2:0];
      end
    end
  end

  asic_unlock_fsm u_unlock (
    .i_clk       (CLK),
    .i_rst_n     (reset_n),
    .i_event     (w_asic_evt),
    .i_byte      (D),
    .i_plus_mode (plus_mode),
    .o_unlocked  (w_unlocked)
  );

  assign asic_unlocked = w_unlocked;
  assign asic_page     = plus_mode & w_unlocked & (r_lrom_loc == 2'b11) & (A[15:14] == 2'b01);

  always_comb begin
    w_lrom_hit = (A[15:14] == 2'b00);
    case (r_lrom_loc)
      2'b01:   w_lrom_hit = (A[15:14] == 2'b01);
      2'b10:   w_lrom_hit = (A[15:14] == 2'b10);
      default: w_lrom_hit = (A[15:14] == 2'b00);
    endcase
  end

  // RAM bank decode for the eight classic expansion configurations
  always_comb begin
    w_pg  = RAM_PAGE_BITS'(BASE_PAGE);
    w_blk = A[15:14];
    if (r_map == 3'b010 || (A[15:14] == 2'b11 && !r_map[2] && r_map[0])) begin
      w_pg = r_page;
    end else if (A[15:14] == 2'b01 && r_map == 3'b011) begin
      w_blk = 2'b11;
    end else if (A[15:14] == 2'b01 && r_map[2]) begin
      w_pg  = r_page;
      w_blk = r_map[1:0];
    end
  end

  always_comb begin
    ram_A        = '0;
    ram_A[13:0]  = A[13:0];
    if (!romen_n && w_lrom_hit) begin
      ram_A[ADDR_W-1]             = 1'b1;
      ram_A[14 +: ROM_BANK_BITS]  = plus_mode ? ROM_BANK_BITS'(r_lrom_bank) : '0;
    end else if (!romen_n && A[15:14] == 2'b11) begin
      ram_A[ADDR_W-1]             = 1'b1;
      ram_A[14 +: ROM_BANK_BITS]  = r_rom_bank;
    end else begin
      ram_A[15:14]                = w_blk;
      ram_A[16 +: RAM_PAGE_BITS]  = w_pg;
    end
  end

endmodule

// File: tb/tb_amstrad_mmu_ext.sv
// Directed scoreboard bench for amstrad_mmu_ext: default instance plus a
// wide-page instance (EXT_A_BITS=3, RAM_PAGE_BITS=8).
module tb_amstrad_mmu_ext;

  localparam int K_RAM0 = 0;
  localparam int K_UNL  = 1;
  localparam int K_PG   = 2;
  localparam int K_RAM1 = 3;

  logic         CLK;
  logic         reset_n;
  logic         ram64k;
  logic         romen_n;
  logic [255:0] rom_map;
  logic         plus_mode;
  logic         io_WR;
  logic [7:0]   D;
  logic [15:0]  A;
  logic [22:0]  ram_a0;
  logic         unl0;
  logic         pg0;
  logic [24:0]  ram_a1;
  logic         unl1;
  logic         pg1;

  int          n_vec;
  int          n_miss;
  int          q_kind [$];
  logic [31:0] q_exp  [$];
  string       q_tag  [$];
  logic [7:0]  useq   [17];

  amstrad_mmu_ext dut0 (
    .CLK(CLK), .reset_n(reset_n), .ram64k(ram64k), .romen_n(romen_n),
    .rom_map(rom_map), .plus_mode(plus_mode), .io_WR(io_WR), .D(D), .A(A),
    .ram_A(ram_a0), .asic_unlocked(unl0), .asic_page(pg0)
  );

  amstrad_mmu_ext #(.RAM_PAGE_BITS(8), .EXT_A_BITS(3), .ROM_BANK_BITS(8), .ADDR_W(25)) dut1 (
    .CLK(CLK), .reset_n(reset_n), .ram64k(ram64k), .romen_n(romen_n),
    .rom_map(rom_map), .plus_mode(plus_mode), .io_WR(io_WR), .D(D), .A(A),
    .ram_A(ram_a1), .asic_unlocked(unl1), .asic_page(pg1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] ram0(input logic [4:0] pg, input logic [1:0] blk, input logic [13:0] off);
    return 32'({2'b00, pg, blk, off});
  endfunction

  function automatic logic [31:0] rom0(input logic [7:0] bk, input logic [13:0] off);
    return 32'({1'b1, bk, off});
  endfunction

  function automatic logic [31:0] ram1(input logic [7:0] pg, input logic [1:0] blk, input logic [13:0] off);
    return 32'({1'b0, pg, blk, off});
  endfunction

  function automatic logic [31:0] observe(input int k);
    case (k)
      K_RAM0:  return 32'(ram_a0);
      K_UNL:   return 32'(unl0);
      K_PG:    return 32'(pg0);
      default: return 32'(ram_a1);
    endcase
  endfunction

  task automatic push(input int k, input logic [31:0] v, input string t);
    q_kind.push_back(k);
    q_exp.push_back(v);
    q_tag.push_back(t);
  endtask

  task automatic probe(input logic [15:0] a, input logic rn);
    int          k;
    logic [31:0] e;
    logic [31:0] o;
    string       t;
    @(negedge CLK);
    A       = a;
    romen_n = rn;
    #1;
    while (q_kind.size() > 0) begin
      k = q_kind.pop_front();
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      o = observe(k);
      n_vec++;
      assert (o === e) else begin
        n_miss++;
        $error("FAIL %s observed=%h expected=%h", t, o, e);
      end
    end
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge CLK);
    A     = a;
    D     = d;
    io_WR = 1'b1;
    @(negedge CLK);
    io_WR = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    useq      = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                  8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'hEE};
    reset_n   = 1'b0;
    io_WR     = 1'b0;
    A         = 16'h0000;
    D         = 8'h00;
    ram64k    = 1'b0;
    romen_n   = 1'b1;
    rom_map   = '0;
    plus_mode = 1'b0;

    // reset state
    push(K_RAM0, ram0(5'd2, 2'b01, 14'h0), "rst_ram");
    push(K_UNL, 32'd0, "rst_unl");
    push(K_PG, 32'd0, "rst_pg");
    push(K_RAM1, ram1(8'd2, 2'b01, 14'h0), "rst_ram1");
    probe(16'h4000, 1'b1);
    @(negedge CLK);
    reset_n = 1'b1;

    push(K_RAM0, ram0(5'd2, 2'b11, 14'h0123), "base_c123");
    probe(16'hC123, 1'b1);
    push(K_RAM0, rom0(8'h00, 14'h0123), "urom_default");
    probe(16'hC123, 1'b0);
    push(K_RAM0, rom0(8'h00, 14'h0010), "lrom_default");
    probe(16'h0010, 1'b0);

    // MMR paging configurations
    io_write(16'h7FFF, 8'hC4);
    push(K_RAM0, ram0(5'd3, 2'b00, 14'h0), "mmr_c4_4000");
    probe(16'h4000, 1'b1);
    push(K_RAM0, ram0(5'd2, 2'b11, 14'h0), "mmr_c4_c000");
    probe(16'hC000, 1'b1);
    io_write(16'h7FFF, 8'hC2);
    push(K_RAM0, ram0(5'd3, 2'b10, 14'h0), "mmr_c2_8000");
    probe(16'h8000, 1'b1);
    push(K_RAM0, ram0(5'd3, 2'b00, 14'h0), "mmr_c2_0000");
    probe(16'h0000, 1'b1);
    io_write(16'h7EFF, 8'hCB);
    push(K_RAM0, ram0(5'd12, 2'b11, 14'h0), "mmr_cb_c000");
    probe(16'hC000, 1'b1);
    push(K_RAM0, ram0(5'd2, 2'b11, 14'h0), "mmr_cb_4000");
    probe(16'h4000, 1'b1);
    ram64k = 1'b1;
    io_write(16'h7FFF, 8'hC7);
    ram64k = 1'b0;
    push(K_RAM0, ram0(5'd12, 2'b11, 14'h0055), "ram64k_block");
    probe(16'hC055, 1'b1);
    io_write(16'h7FFF, 8'hC0);
    push(K_RAM0, ram0(5'd2, 2'b01, 14'h0), "mmr_c0_4000");
    probe(16'h4000, 1'b1);

    // upper ROM select
    rom_map[7] = 1'b1;
    io_write(16'hDF00, 8'h07);
    push(K_RAM0, rom0(8'h07, 14'h0123), "rom7_present");
    probe(16'hC123, 1'b0);
    rom_map[7] = 1'b0;
    io_write(16'hDF00, 8'h07);
    push(K_RAM0, rom0(8'h00, 14'h0123), "rom7_absent");
    probe(16'hC123, 1'b0);
    rom_map[8'hC5] = 1'b1;
    io_write(16'h5FFF, 8'hC5);
    push(K_RAM0, rom0(8'hC5, 14'h0123), "both_rom");
    probe(16'hC123, 1'b0);
    push(K_RAM0, ram0(5'd3, 2'b01, 14'h0), "both_mmr");
    probe(16'h4000, 1'b1);
    io_write(16'h7FFF, 8'hC0);

    // unlock sequence
    plus_mode = 1'b1;
    for (int i = 0; i < 16; i++) io_write(16'hBC00, useq[i]);
    push(K_UNL, 32'd0, "unl_16_bytes");
    probe(16'h0000, 1'b1);
    io_write(16'hBC00, 8'hEF);
    push(K_UNL, 32'd0, "unl_bad_last");
    probe(16'h0000, 1'b1);
    for (int i = 0; i < 17; i++) io_write(16'hBC00, useq[i]);
    push(K_UNL, 32'd1, "unl_full");
    push(K_PG, 32'd0, "pg_before_rmr2");
    probe(16'h4000, 1'b1);

    // RMR2 lower-ROM control
    io_write(16'h7F00, 8'hB9);
    push(K_PG, 32'd1, "pg_rmr2_b9");
    probe(16'h4000, 1'b1);
    push(K_RAM0, rom0(8'h01, 14'h0010), "lrom_b9_0010");
    probe(16'h0010, 1'b0);
    push(K_RAM0, ram0(5'd2, 2'b01, 14'h0), "lrom_b9_4000");
    probe(16'h4000, 1'b0);
    io_write(16'h7F00, 8'hA8);
    push(K_RAM0, rom0(8'h00, 14'h0), "lrom_a8_4000");
    probe(16'h4000, 1'b0);
    push(K_PG, 32'd0, "pg_rmr2_a8");
    probe(16'h4000, 1'b1);
    io_write(16'h7F00, 8'hB9);
    io_write(16'hBC00, 8'h12);
    push(K_UNL, 32'd0, "relock_unl");
    push(K_PG, 32'd0, "relock_pg");
    probe(16'h4000, 1'b1);
    push(K_RAM0, rom0(8'h01, 14'h0010), "relock_lrom");
    probe(16'h0010, 1'b0);
    plus_mode = 1'b0;
    push(K_RAM0, rom0(8'h00, 14'h0010), "lrom_noplus");
    probe(16'h0010, 1'b0);

    // plus_mode drop forces lock
    plus_mode = 1'b1;
    for (int i = 0; i < 17; i++) io_write(16'hBC00, useq[i]);
    push(K_UNL, 32'd1, "unl_again");
    probe(16'h0000, 1'b1);
    plus_mode = 1'b0;
    push(K_UNL, 32'd0, "plus_off");
    probe(16'h0000, 1'b1);
    plus_mode = 1'b1;
    push(K_UNL, 32'd0, "plus_back_on");
    probe(16'h0000, 1'b1);

    // reset part-way through the sequence
    for (int i = 0; i < 8; i++) io_write(16'hBC00, useq[i]);
    @(negedge CLK);
    reset_n = 1'b0;
    @(negedge CLK);
    reset_n = 1'b1;
    for (int i = 8; i < 17; i++) io_write(16'hBC00, useq[i]);
    push(K_UNL, 32'd0, "unl_after_reset");
    probe(16'h0000, 1'b1);
    for (int i = 0; i < 17; i++) io_write(16'hBC00, useq[i]);
    push(K_UNL, 32'd1, "unl_fresh");
    probe(16'h0000, 1'b1);

    // wide page instance
    io_write(16'h78FF, 8'hFF);
    push(K_RAM1, ram1(8'h42, 2'b11, 14'h0), "wide_ff_4000");
    probe(16'h4000, 1'b1);
    io_write(16'h78FF, 8'hF9);
    push(K_RAM1, ram1(8'h42, 2'b11, 14'h0), "wide_f9_c000");
    probe(16'hC000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
